// File: rtl/seg_scan_capture.sv
// Seven-segment scan-bus receiver: rebuilds four hex digits from the multiplexed
// anode/segment lines and commits one coherent frame per 0,3,2,1 scan. Optional watchdog: SCAN_TIMEOUT_EN.
module seg_scan_capture #(
  parameter int STABLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [3:0]  seg_bad,
  output logic        scan_timeout
);

  localparam int DW = $clog2(STABLE_CYC + 1);
  localparam logic [DW-1:0] STABLE_MAX = DW'(STABLE_CYC);

  typedef enum logic {SYNC, COLLECT} state_t;

  logic [3:0]    an_q, an_prev_q;
  logic [6:0]    seg_q;
  logic [DW-1:0] dwell_q, dwell_d;
  state_t        state_q, state_d;
  logic [1:0]    expected_q, expected_d;
  logic [15:0]   stage_q, stage_d;
  logic [3:0]    stage_bad_q, stage_bad_d;
  logic [15:0]   digits_q, digits_d;
  logic [3:0]    seg_bad_q, seg_bad_d;
  logic          frame_valid_q, frame_valid_d;
  logic          frame_err_q, frame_err_d;

  logic          an_changed, at_stable, capture, code_err;
  logic [3:0]    sel;
  logic          sel_blank, sel_onehot;
  logic [1:0]    cap_idx;
  logic [4:0]    dec;

  // Returns {bad, nibble}; unknown patterns decode to nibble 0 with bad set.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'b1000000: decode_seg = 5'h00;
      7'b1111001: decode_seg = 5'h01;
      7'b0100100: decode_seg = 5'h02;
      7'b0110000: decode_seg = 5'h03;
      7'b0011001: decode_seg = 5'h04;
      7'b0010010: decode_seg = 5'h05;
      7'b0000010: decode_seg = 5'h06;
      7'b1111000: decode_seg = 5'h07;
      7'b0000000: decode_seg = 5'h08;
      7'b0010000: decode_seg = 5'h09;
      7'b0001000: decode_seg = 5'h0A;
      7'b0000011: decode_seg = 5'h0B;
      7'b1000110: decode_seg = 5'h0C;
      7'b0100001: decode_seg = 5'h0D;
      7'b0000110: decode_seg = 5'h0E;
      7'b0001110: decode_seg = 5'h0F;
      default:    decode_seg = 5'h10;
    endcase
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_sel
    assign sel[gi] = ~an_q[gi];
  end

  assign sel_blank  = (sel == 4'b0000);
  assign sel_onehot = !sel_blank && ((sel & (sel - 4'd1)) == 4'b0000);
  assign an_changed = (an_q != an_prev_q);
  assign dec        = decode_seg(seg_q);

  always_comb begin
    dwell_d = dwell_q;
    if (an_changed)
      dwell_d = DW'(1);
    else if (dwell_q < STABLE_MAX)
      dwell_d = dwell_q + DW'(1);
  end

  // Fire once per dwell: the counter must be arriving at STABLE_CYC, not sitting there.
  assign at_stable = (dwell_d == STABLE_MAX) && (an_changed || dwell_q != STABLE_MAX);
  assign capture   = at_stable && sel_onehot;
  assign code_err  = at_stable && !sel_onehot && !sel_blank;

  always_comb begin
    cap_idx = 2'd0;
    case (an_q)
      4'b1101: cap_idx = 2'd1;
      4'b1011: cap_idx = 2'd2;
      4'b0111: cap_idx = 2'd3;
      default: cap_idx = 2'd0;
    endcase
  end

`ifdef SCAN_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          timeout_q, timeout_d;
`endif

  always_comb begin
    state_d       = state_q;
    expected_d    = expected_q;
    stage_d       = stage_q;
    stage_bad_d   = stage_bad_q;
    digits_d      = digits_q;
    seg_bad_d     = seg_bad_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    if (code_err) begin
      frame_err_d = 1'b1;
      stage_d     = '0;
      stage_bad_d = '0;
      expected_d  = 2'd0;
      state_d     = SYNC;
    end else if (capture) begin
      if (state_q == SYNC) begin
        if (cap_idx == 2'd0) begin
          stage_d[3:0]   = dec[3:0];
          stage_bad_d[0] = dec[4];
          expected_d     = 2'd3;
          state_d        = COLLECT;
        end
      end else if (cap_idx == expected_q) begin
        if (cap_idx == 2'd1) begin
          digits_d       = stage_q;
          digits_d[7:4]  = dec[3:0];
          seg_bad_d      = stage_bad_q;
          seg_bad_d[1]   = dec[4];
          frame_valid_d  = 1'b1;
          stage_d        = '0;
          stage_bad_d    = '0;
          expected_d     = 2'd0;
        end else begin
          stage_d[cap_idx*4 +: 4] = dec[3:0];
          stage_bad_d[cap_idx]    = dec[4];
          expected_d              = expected_q - 2'd1;
        end
      end else begin
        frame_err_d = 1'b1;
        stage_d     = '0;
        stage_bad_d = '0;
        if (cap_idx == 2'd0) begin
          stage_d[3:0]   = dec[3:0];
          stage_bad_d[0] = dec[4];
          expected_d     = 2'd3;
        end else begin
          expected_d = 2'd0;
          state_d    = SYNC;
        end
      end
    end

`ifdef SCAN_TIMEOUT_EN
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    if (capture) begin
      wdog_d    = '0;
      timeout_d = 1'b0;
    end else if (wdog_q != WW'(TIMEOUT_CYC)) begin
      wdog_d = wdog_q + WW'(1);
      if (wdog_d == WW'(TIMEOUT_CYC)) begin
        timeout_d   = 1'b1;
        stage_d     = '0;
        stage_bad_d = '0;
        expected_d  = 2'd0;
        state_d     = SYNC;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      an_q          <= 4'hF;
      an_prev_q     <= 4'hF;
      seg_q         <= 7'h7F;
      dwell_q       <= '0;
      state_q       <= SYNC;
      expected_q    <= 2'd0;
      stage_q       <= '0;
      stage_bad_q   <= '0;
      digits_q      <= '0;
      seg_bad_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      an_q          <= an;
      an_prev_q     <= an_q;
      seg_q         <= seg;
      dwell_q       <= dwell_d;
      state_q       <= state_d;
      expected_q    <= expected_d;
      stage_q       <= stage_d;
      stage_bad_q   <= stage_bad_d;
      digits_q      <= digits_d;
      seg_bad_q     <= seg_bad_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

`ifdef SCAN_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign scan_timeout = timeout_q;
`else
  // TIMEOUT_CYC only matters when the watchdog is compiled in.
  assign scan_timeout = 1'b0 & (TIMEOUT_CYC < 1);
`endif

  assign digits      = digits_q;
  assign seg_bad     = seg_bad_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: drives scan sequences and checks committed frames,
// error pulses and (when SCAN_TIMEOUT_EN is defined) the watchdog.
module tb_seg_scan_capture;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic        frame_valid, frame_err, scan_timeout;
  logic [3:0]  seg_bad;

  int pass_cnt = 0, total_cnt = 0;
  int fv_cnt = 0, fe_cnt = 0, both_cnt = 0;

  seg_scan_capture #(.STABLE_CYC(2), .TIMEOUT_CYC(16)) dut (
    .clock(clk), .reset(rst_n), .an(an), .seg(seg), .digits(digits),
    .frame_valid(frame_valid), .frame_err(frame_err), .seg_bad(seg_bad),
    .scan_timeout(scan_timeout)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (frame_valid) fv_cnt++;
    if (frame_err) fe_cnt++;
    if (frame_valid && frame_err) both_cnt++;
  end

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: seg_of = 7'b1000000;  1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;  3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;  5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;  7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;  9: seg_of = 7'b0010000;
      10: seg_of = 7'b0001000; 11: seg_of = 7'b0000011;
      12: seg_of = 7'b1000110; 13: seg_of = 7'b0100001;
      14: seg_of = 7'b0000110; default: seg_of = 7'b0001110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input int d, input int v, input int n);
    logic [3:0] a;
    a    = 4'hF;
    a[d] = 1'b0;
    hold(a, seg_of(v), n);
  endtask

  initial begin
    rst_n = 1'b0;
    an    = 4'hF;
    seg   = 7'h7F;
    repeat (3) @(negedge clk);
    check("rst_digits", digits, 16'h0000);
    check("rst_seg_bad", seg_bad, 4'b0000);
    check("rst_frame_valid", frame_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_scan_timeout", scan_timeout, 1'b0);
    rst_n = 1'b1;
    hold(4'hF, 7'h7F, 2);

    // Basic frame: digit0=4, digit3=1, digit2=2, digit1=3
    scan(0, 4, 4); scan(3, 1, 4); scan(2, 2, 4); scan(1, 3, 4);
    hold(4'hF, 7'h7F, 2);
    check("f1_valid_cnt", fv_cnt, 1);
    check("f1_digits", digits, 16'h1234);
    check("f1_seg_bad", seg_bad, 4'b0000);
    check("f1_err_cnt", fe_cnt, 0);

    // Reset mid-frame, then start on digit 3 before any digit 0
    scan(0, 7, 4); scan(3, 7, 4);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_digits", digits, 16'h0000);
    check("mrst_seg_bad", seg_bad, 4'b0000);
    check("mrst_valid", frame_valid, 1'b0);
    check("mrst_timeout", scan_timeout, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    scan(3, 9, 4); scan(2, 9, 4); scan(1, 9, 4);
    check("presync_valid_cnt", fv_cnt, 1);
    check("presync_err_cnt", fe_cnt, 0);
    check("presync_digits", digits, 16'h0000);
    scan(0, 5, 4); scan(3, 6, 4); scan(2, 7, 4); scan(1, 8, 4);
    check("f2_valid_cnt", fv_cnt, 2);
    check("f2_digits", digits, 16'h6785);

    // Skipped digit 3 -> rotation error, no commit
    scan(0, 10, 4); scan(2, 12, 4);
    check("skip_err_cnt", fe_cnt, 1);
    check("skip_valid_cnt", fv_cnt, 2);
    check("skip_digits", digits, 16'h6785);
    scan(0, 10, 4); scan(3, 13, 4); scan(2, 12, 4); scan(1, 11, 4);
    check("f3_valid_cnt", fv_cnt, 3);
    check("f3_digits", digits, 16'hDCBA);
    check("f3_err_cnt", fe_cnt, 1);

    // Illegal anode code, then digit 3 must be ignored (SYNC), then long blank
    hold(4'b1100, seg_of(0), 3);
    check("illegal_err_cnt", fe_cnt, 2);
    scan(3, 1, 4);
    check("sync_ignore_err_cnt", fe_cnt, 2);
    hold(4'hF, 7'h7F, 10);
    check("blank_err_cnt", fe_cnt, 2);
    check("blank_valid_cnt", fv_cnt, 3);

    // Undecodable pattern on digit 2
    scan(0, 0, 4); scan(3, 15, 4); hold(4'b1011, 7'b1111111, 4); scan(1, 1, 4);
    check("bad_valid_cnt", fv_cnt, 4);
    check("bad_digits", digits, 16'hF010);
    check("bad_seg_bad", seg_bad, 4'b0100);

    // Unexpected digit 0 mid-frame resyncs immediately
    scan(0, 1, 4); scan(3, 2, 4); scan(0, 3, 4);
    check("resync_err_cnt", fe_cnt, 3);
    scan(3, 4, 4); scan(2, 5, 4); scan(1, 6, 4);
    check("resync_valid_cnt", fv_cnt, 5);
    check("resync_digits", digits, 16'h4563);
    check("resync_seg_bad", seg_bad, 4'b0000);

    // One-cycle anode glitch shorter than the dwell threshold is ignored
    scan(0, 8, 4); scan(3, 9, 4); scan(1, 0, 1); scan(2, 10, 4); scan(1, 11, 4);
    check("glitch_valid_cnt", fv_cnt, 6);
    check("glitch_digits", digits, 16'h9AB8);
    check("glitch_err_cnt", fe_cnt, 3);

    // Stalled scan mid-frame
    scan(0, 1, 4); scan(3, 2, 4);
    hold(4'hF, 7'h7F, 8);
    check("stall_early_timeout", scan_timeout, 1'b0);
    hold(4'hF, 7'h7F, 17);
    check("stall_digits", digits, 16'h9AB8);
`ifdef SCAN_TIMEOUT_EN
    check("stall_timeout", scan_timeout, 1'b1);
    scan(0, 3, 4);
    check("resume_timeout", scan_timeout, 1'b0);
    check("resume_err_cnt", fe_cnt, 3);
    scan(3, 6, 4); scan(2, 5, 4); scan(1, 4, 4);
    check("resume_valid_cnt", fv_cnt, 7);
    check("resume_digits", digits, 16'h6543);
`else
    check("stall_timeout", scan_timeout, 1'b0);
    scan(2, 5, 4); scan(1, 4, 4);
    check("resume_valid_cnt", fv_cnt, 7);
    check("resume_digits", digits, 16'h2541);
    check("resume_err_cnt", fe_cnt, 3);
`endif
    check("never_both_pulse", both_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
